// File: rtl/mult_share_sched.sv
// Round-robin scheduler that time-shares one shift-add signed multiplier
// datapath among NREQ requesters. It grants one requester, steers its
// operands into the datapath through Sel, then sequences clear/load,
// add/subtract and shift for WIDTH bits before pulsing that requester's Done.
module mult_share_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    localparam int SW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] Req,
    input  logic            M,
    output logic [NREQ-1:0] Gnt,
    output logic [SW-1:0]   Sel,
    output logic            Clr_Ld,
    output logic            Add,
    output logic            Sub,
    output logic            Shift_En,
    output logic [NREQ-1:0] Done,
    output logic            Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   k;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   sel_r;
    logic [NREQ-1:0] gnt_r;
    logic [SW-1:0]   pick;
    logic            pick_valid;
    logic [SW:0]     cand;
    logic            last_bit;

    // The final multiplier bit carries negative weight, so it subtracts.
    assign last_bit = (k == CW'(WIDTH - 1));

    // Round-robin pick: first asserted Req at or after ptr, wrapping around.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (SW+1)'(i);
            if (cand >= (SW+1)'(NREQ)) begin
                cand = cand - (SW+1)'(NREQ);
            end
            if (!pick_valid && Req[cand[SW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = cand[SW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing: IDLE -> LOAD -> {ADD -> SHIFT} x WIDTH -> DONE -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (pick_valid) next_state = S_LOAD;
            S_LOAD:  next_state = S_ADD;
            S_ADD:   next_state = S_SHIFT;
            S_SHIFT: next_state = last_bit ? S_DONE : S_ADD;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Grant, select, bit counter and round-robin pointer registers.
    always_ff @(posedge Clk) begin
        // NOTE: synchronous reset clears only control state; an aborted operation simply vanishes.
        if (!Reset) begin
            gnt_r <= '0;
            sel_r <= '0;
            ptr   <= '0;
            k     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        sel_r <= pick;
                        gnt_r <= NREQ'(1) << pick;
                    end
                end
                S_LOAD: k <= '0;
                S_SHIFT: begin
                    if (!last_bit) begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    gnt_r <= '0;
                    ptr   <= (sel_r == SW'(NREQ - 1)) ? '0 : sel_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath controls decoded from registered state; M only gates add/subtract.
    always_comb begin
        Gnt      = gnt_r;
        Sel      = sel_r;
        Busy     = (state != S_IDLE);
        Clr_Ld   = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Done     = '0;
        case (state)
            S_LOAD:  Clr_Ld = 1'b1;
            S_ADD: begin
                Add = M && !last_bit;
                Sub = M && last_bit;
            end
            S_SHIFT: Shift_En = 1'b1;
            S_DONE:  Done = gnt_r;
            default: ;
        endcase
    end

endmodule
